mips_reg_file: RTL and testbench
================================

# mips_reg_file

- Architectural register file for the single-cycle R-type datapath.
- Two combinational read ports: rs drives ALU operand A, rt drives ALU operand B.
- One synchronous write port: stores the ALU result into rd at the end of the instruction's cycle.
- Also provides a registered debug read port and a write-event counter for bench observation.

## Interface

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width; depth is 2^ADDR_W

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- rs_addr  input  ADDR_W  read port A address (instr[25:21])
- rt_addr  input  ADDR_W  read port B address (instr[20:16])
- rd_addr  input  ADDR_W  write address (instr[15:11])
- wr_en  input  1  write enable (RegWrite from control)
- wr_data  input  DATA_W  write data (ALU result)
- rs_data  output  DATA_W  contents of rs_addr, combinational
- rt_data  output  DATA_W  contents of rt_addr, combinational
- dbg_addr  input  ADDR_W  debug read address
- dbg_data  output  DATA_W  contents of dbg_addr, registered
- wr_count  output  16  count of committed writes to non-zero registers

## Operation

**Reset**
- Reset is asynchronous, active-low (rst_n = 0).
- Clears all 2^ADDR_W registers, dbg_data and wr_count to 0.
- While reset is asserted, rs_data and rt_data read 0 for every address.

**Reads**
- rs_data = reg[rs_addr] and rt_data = reg[rt_addr], purely combinational.
- Address 0 always returns 0.

**Writes**
- On a rising clk edge with wr_en = 1 and rd_addr != 0: reg[rd_addr] <= wr_data, and wr_count increments by 1.
- wr_count wraps from 0xFFFF to 0x0000.

**Register 0**
- Hard-wired to zero.
- A write with rd_addr = 0 is dropped: no storage change, no wr_count increment.

**No write-through bypass**
- A read of the address being written returns the old value until the edge.
- This is mandatory: wr_data is derived combinationally from rs_data/rt_data through the ALU, so a bypass would form a combinational loop.

**Debug port**
- dbg_data <= reg[dbg_addr] on every rising edge.
- The value captured is the pre-edge contents: a write and a debug read of the same address in the same cycle capture the old value, and the new value appears one cycle later.
- dbg_addr = 0 yields 0.

**Simultaneous events**
- rs_addr = rt_addr = rd_addr with wr_en = 1: both read ports show the old value during the cycle and the new value after the edge.
- Reset asserted mid-cycle overrides any pending write; that write is lost.

## Timing

- Read latency: 0 cycles (combinational from address and stored state).
- Write latency: 1 edge. The value is visible on rs_data/rt_data immediately after the edge that committed it.
- Debug latency: 1 cycle from dbg_addr to dbg_data.
- Full single-cycle critical path: register read → ALU → wr_data setup at the next edge. The file adds only mux delay on reads and setup on writes.
- Reset release: the first write can occur on the first rising edge after rst_n deasserts. Synchronising rst_n deassertion is external to this block.

## Structure

Shared package holds:
- DATA_W = 32, ADDR_W = 5
- REG_ZERO = 0
- Named register indices used by the bench (e.g. T0 = 8, S0 = 16)

RTL organisation:
- Storage is a single array of 2^ADDR_W × DATA_W flops with asynchronous clear.
- No sub-module; read muxes, write decode and counter stay in one module.
- Top-level datapath instantiates this block upstream of the ALU and feeds ALU out back to wr_data.

## Test plan

1. Reset: hold rst_n = 0, then release. Sweep rs_addr/rt_addr over 0..31 → every read is 0; wr_count = 0; dbg_data = 0.
2. Basic write/read: write 0xDEADBEEF to r8. In the next cycle set rs_addr = 8 → rs_data = 0xDEADBEEF; wr_count = 1.
3. Register 0 protection: wr_en = 1, rd_addr = 0, wr_data = 0xFFFFFFFF → rs_addr = 0 reads 0; wr_count unchanged.
4. Same-cycle read/write: r9 = 5, then write 7 to r9 with rs_addr = rt_addr = dbg_addr = 9.
   - rs_data and rt_data = 5 before the edge, 7 after.
   - dbg_data = 5 after the first edge, 7 after the second.
5. Async reset mid-operation: write r10 = 0x1234, then pulse rst_n low between edges.
   - r10 reads 0 immediately (before the next edge).
   - A write presented during reset is not committed.
6. Counter wrap: perform 65536 writes to r1 → wr_count returns to 0. Interleaved writes to r0 do not count.

Source files
------------

// File: rtl/mips_reg_file_pkg.sv
// ----------------------------------------------------------------------------
// mips_reg_file_pkg
//   Shared constants for the MIPS architectural register file.
//   Holds the default data/address widths, the index of the hard-wired
//   zero register, and the conventional MIPS register names that the
//   datapath and the bench use.
// ----------------------------------------------------------------------------
package mips_reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int CNT_W    = 16;

  // Register 0 reads as zero and ignores writes.
  localparam int REG_ZERO = 0;

  // Conventional MIPS register names.
  localparam int AT = 1;
  localparam int V0 = 2;
  localparam int A0 = 4;
  localparam int T0 = 8;
  localparam int T1 = 9;
  localparam int T2 = 10;
  localparam int S0 = 16;
  localparam int SP = 29;
  localparam int RA = 31;

endpackage : mips_reg_file_pkg

// File: rtl/mips_reg_file.sv
// ----------------------------------------------------------------------------
// mips_reg_file
//   Architectural register file for the single-cycle R-type datapath.
//
//   Ports
//     clk       : single clock, all state updates on the rising edge
//     rst_n     : asynchronous active-low reset, clears all state
//     rs_addr   : read port A address (ALU operand A)
//     rt_addr   : read port B address (ALU operand B)
//     rd_addr   : write address
//     wr_en     : write enable (RegWrite)
//     wr_data   : write data (ALU result)
//     rs_data   : contents of rs_addr, combinational
//     rt_data   : contents of rt_addr, combinational
//     dbg_addr  : debug read address
//     dbg_data  : contents of dbg_addr, registered (pre-edge value)
//     wr_count  : count of committed writes to non-zero registers, wraps
//
//   Reads deliberately have no write-through bypass: wr_data is produced
//   combinationally from rs_data/rt_data through the ALU, so forwarding
//   wr_data onto the read ports would close a combinational loop.
// ----------------------------------------------------------------------------
module mips_reg_file #(
  parameter int DATA_W = mips_reg_file_pkg::DATA_W,
  parameter int ADDR_W = mips_reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  import mips_reg_file_pkg::*;

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_commit;

  // Writes to register 0 are dropped entirely, including the count.
  assign wr_commit = wr_en && (rd_addr != ZERO_ADDR);

  // Storage. Entry 0 is never written, so it stays at its reset value;
  // the read muxes still force it to zero so the hard-wiring does not
  // depend on that flop surviving synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[rd_addr] <= wr_data;
    end
  end

  // Combinational read ports, old value until the committing edge.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != ZERO_ADDR) rs_data = regs[rs_addr];
    if (rt_addr != ZERO_ADDR) rt_data = regs[rt_addr];
  end

  // Debug port samples the pre-edge contents, so a same-cycle write to
  // dbg_addr shows up one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_data <= '0;
    end else if (dbg_addr == ZERO_ADDR) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= regs[dbg_addr];
    end
  end

  // Committed-write counter, free-running wrap at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (wr_commit) begin
      wr_count <= wr_count + 16'd1;
    end
  end

endmodule : mips_reg_file

// File: tb/tb_mips_reg_file.sv
// ----------------------------------------------------------------------------
// tb_mips_reg_file
//   Directed bench for mips_reg_file. Stimulus drives inputs just after a
//   rising edge and queues the values the outputs must hold for that cycle;
//   a monitor drains the queue on the falling edge and compares.
// ----------------------------------------------------------------------------
module tb_mips_reg_file;

  import mips_reg_file_pkg::*;

  localparam int P_RS  = 0;
  localparam int P_RT  = 1;
  localparam int P_DBG = 2;
  localparam int P_CNT = 3;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [15:0]       wr_count;

  mips_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] val;
  } chk_t;

  chk_t q[$];
  chk_t cur;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] act;

  task automatic expect_val(input string name, input int port, input logic [31:0] v);
    chk_t c;
    c.name = name;
    c.port = port;
    c.val  = v;
    q.push_back(c);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input int rd, input logic [31:0] d,
                       input int rs, input int rt, input int dbg);
    wr_en    = we;
    rd_addr  = ADDR_W'(rd);
    wr_data  = d;
    rs_addr  = ADDR_W'(rs);
    rt_addr  = ADDR_W'(rt);
    dbg_addr = ADDR_W'(dbg);
  endtask

  // Monitor: every queued expectation refers to the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      cur = q.pop_front();
      case (cur.port)
        P_RS:    act = rs_data;
        P_RT:    act = rt_data;
        P_DBG:   act = dbg_data;
        default: act = {16'h0, wr_count};
      endcase
      checks++;
      if (act !== cur.val) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", cur.name, act, cur.val, $time);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 0, 32'h0, 0, 0, 0);
    #1 rst_n = 1'b0;

    // 1. reset state, during and after reset
    drive(1'b0, 0, 32'h0, T0, RA, S0);
    expect_val("rst_hold_rs", P_RS, 32'h0);
    expect_val("rst_hold_rt", P_RT, 32'h0);
    expect_val("rst_hold_cnt", P_CNT, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 0, 32'h0, i, 31 - i, i);
      expect_val("rst_sweep_rs", P_RS, 32'h0);
      expect_val("rst_sweep_rt", P_RT, 32'h0);
      expect_val("rst_sweep_dbg", P_DBG, 32'h0);
      cyc();
    end
    expect_val("rst_cnt", P_CNT, 32'h0);

    // 2. basic write then read; no bypass during the write cycle
    drive(1'b1, T0, 32'hDEADBEEF, T0, T0, 0);
    expect_val("wr_nobypass_rs", P_RS, 32'h0);
    expect_val("wr_pre_cnt", P_CNT, 32'h0);
    cyc();
    drive(1'b0, 0, 32'h0, T0, T0, T0);
    expect_val("wr_read_rs", P_RS, 32'hDEADBEEF);
    expect_val("wr_read_rt", P_RT, 32'hDEADBEEF);
    expect_val("wr_cnt1", P_CNT, 32'h1);
    cyc();
    expect_val("wr_dbg", P_DBG, 32'hDEADBEEF);

    // 3. register 0 protection
    drive(1'b1, REG_ZERO, 32'hFFFFFFFF, REG_ZERO, REG_ZERO, REG_ZERO);
    cyc();
    drive(1'b0, 0, 32'h0, REG_ZERO, REG_ZERO, REG_ZERO);
    expect_val("r0_rs", P_RS, 32'h0);
    expect_val("r0_rt", P_RT, 32'h0);
    expect_val("r0_cnt", P_CNT, 32'h1);
    cyc();
    expect_val("r0_dbg", P_DBG, 32'h0);

    // 4. same-cycle read/write of one register
    drive(1'b1, T1, 32'h5, 0, 0, 0);
    cyc();
    drive(1'b1, T1, 32'h7, T1, T1, T1);
    expect_val("same_pre_rs", P_RS, 32'h5);
    expect_val("same_pre_rt", P_RT, 32'h5);
    expect_val("same_pre_cnt", P_CNT, 32'h2);
    cyc();
    drive(1'b0, 0, 32'h0, T1, T1, T1);
    expect_val("same_post_rs", P_RS, 32'h7);
    expect_val("same_post_rt", P_RT, 32'h7);
    expect_val("same_dbg_old", P_DBG, 32'h5);
    expect_val("same_post_cnt", P_CNT, 32'h3);
    cyc();
    expect_val("same_dbg_new", P_DBG, 32'h7);

    // 5. async reset mid-cycle, write held through reset is lost
    drive(1'b1, T2, 32'h1234, 0, 0, 0);
    cyc();
    drive(1'b0, 0, 32'h0, T2, T0, T2);
    expect_val("mid_pre_rs", P_RS, 32'h1234);
    expect_val("mid_pre_cnt", P_CNT, 32'h4);
    cyc();
    drive(1'b1, T2, 32'h0000AAAA, T2, T0, T2);
    #1 rst_n = 1'b0;
    expect_val("mid_rst_rs", P_RS, 32'h0);
    expect_val("mid_rst_rt", P_RT, 32'h0);
    expect_val("mid_rst_dbg", P_DBG, 32'h0);
    expect_val("mid_rst_cnt", P_CNT, 32'h0);
    cyc();
    drive(1'b0, 0, 32'h0, T2, S0, T2);
    rst_n = 1'b1;
    expect_val("mid_lost_rs", P_RS, 32'h0);
    expect_val("mid_lost_cnt", P_CNT, 32'h0);
    cyc();
    expect_val("mid_after_rs", P_RS, 32'h0);
    expect_val("mid_after_dbg", P_DBG, 32'h0);

    // 6. counter wrap with interleaved r0 writes
    for (int i = 0; i < 65535; i++) begin
      if ((i % 8192) == 0) begin
        drive(1'b1, REG_ZERO, 32'hFFFFFFFF, 0, 0, 0);
        cyc();
      end
      drive(1'b1, AT, i, 0, 0, 0);
      cyc();
    end
    drive(1'b0, 0, 32'h0, AT, REG_ZERO, AT);
    expect_val("wrap_max_cnt", P_CNT, 32'h0000FFFF);
    expect_val("wrap_max_rs", P_RS, 32'd65534);
    expect_val("wrap_r0_rt", P_RT, 32'h0);
    cyc();
    drive(1'b1, AT, 32'hCAFE, AT, AT, 0);
    expect_val("wrap_pre_cnt", P_CNT, 32'h0000FFFF);
    expect_val("wrap_pre_rs", P_RS, 32'd65534);
    cyc();
    drive(1'b0, 0, 32'h0, AT, REG_ZERO, 0);
    expect_val("wrap_zero_cnt", P_CNT, 32'h0);
    expect_val("wrap_post_rs", P_RS, 32'hCAFE);
    expect_val("wrap_post_rt", P_RT, 32'h0);
    cyc();
    cyc();

    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mips_reg_file
